// File: rtl/snow_anim_ctrl.sv
// Snow sprite frame sequencer: animation prescaler, per-mode frame stepping,
// and frame changes applied only on the registered rising edge of vblank.
module snow_anim_ctrl #(
    parameter int FRAMES   = 3,
    parameter int TICK_DIV = 6000000,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              en,
    input  logic              vblank,
    input  logic [ADDR_W-1:0] snow_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        frame_sel,
    output logic              busy,
    output logic              done
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [1:0]      LAST      = 2'(FRAMES - 1);

    localparam logic [1:0] MODE_LOOP = 2'b00;
    localparam logic [1:0] MODE_PING = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        frame_q, frame_d;
    logic              dir_q, dir_d;       // 0 = counting up
    logic [PW-1:0]     presc_q, presc_d;
    logic              pending_q, pending_d;
    logic [1:0]        mode_q, mode_d;
    logic              done_q, done_d;
    logic              vb_q, vb_prev_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              vb_edge;
    logic              tick;

    // vblank is registered first, so its edge acts one cycle after first sampled high
    assign vb_edge = vb_q & ~vb_prev_q;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        pending_d = pending_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        tick      = 1'b0;
        if (start) begin
            state_d   = RUN;
            frame_d   = 2'd0;
            dir_d     = 1'b0;
            presc_d   = '0;
            pending_d = 1'b0;
            mode_d    = mode;
        end else if (state_q == RUN) begin
            if (en) begin
                if (presc_q == PRESC_MAX) begin
                    tick      = 1'b1;
                    presc_d   = '0;
                    pending_d = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            if (vb_edge && (pending_q || tick)) begin
                pending_d = 1'b0;
                case (mode_q)
                    MODE_LOOP: frame_d = (frame_q == LAST) ? 2'd0 : frame_q + 2'd1;
                    MODE_PING: begin
                        if (FRAMES > 1) begin
                            if (!dir_q) begin
                                if (frame_q == LAST) begin
                                    frame_d = frame_q - 2'd1;
                                    dir_d   = 1'b1;
                                end else begin
                                    frame_d = frame_q + 2'd1;
                                end
                            end else begin
                                if (frame_q == 2'd0) begin
                                    frame_d = 2'd1;
                                    dir_d   = 1'b0;
                                end else begin
                                    frame_d = frame_q - 2'd1;
                                end
                            end
                        end
                    end
                    MODE_ONE: begin
                        if (frame_q == LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= 2'd0;
            dir_q      <= 1'b0;
            presc_q    <= '0;
            pending_q  <= 1'b0;
            mode_q     <= 2'b00;
            done_q     <= 1'b0;
            vb_q       <= 1'b0;
            vb_prev_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            dir_q      <= dir_d;
            presc_q    <= presc_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            vb_q       <= vblank;
            vb_prev_q  <= vb_q;
            rom_addr_q <= snow_addr;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign frame_sel = frame_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_snow_anim_ctrl.sv
// Directed bench for snow_anim_ctrl: driver pushes expected frame/done events,
// a monitor pops them whenever frame_sel changes or done pulses.
module tb_snow_anim_ctrl;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, start, en, vblank;
    logic [1:0]    mode;
    logic [AW-1:0] snow_addr;
    logic [AW-1:0] rom_addr;
    logic [1:0]    frame_sel;
    logic          busy, done;

    always #5 clk = ~clk;

    snow_anim_ctrl #(.FRAMES(3), .TICK_DIV(4), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .en(en),
        .vblank(vblank), .snow_addr(snow_addr), .rom_addr(rom_addr),
        .frame_sel(frame_sel), .busy(busy), .done(done)
    );

    // entry = {check vblank alignment, done, frame[1:0]}
    logic [3:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic chk, input logic d, input logic [1:0] f);
        exp_q.push_back({chk, d, f});
    endtask

    task automatic start_anim(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        cyc(1);
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic vb_pulse(input int period);
        vblank = 1'b1;
        cyc(2);
        vblank = 1'b0;
        cyc(period - 2);
    endtask

    task automatic vb_adv(input int period, input logic [1:0] f);
        push(1'b1, 1'b0, f);
        vb_pulse(period);
    endtask

    initial begin
        snow_addr = '0;
        forever begin
            @(negedge clk);
            snow_addr = snow_addr + 12'h1a7;
        end
    end

    // monitor: samples 1 time unit after each rising edge
    initial begin : monitor
        logic [1:0] last_frame;
        logic       vb_last, rise_last;
        logic [3:0] e;
        last_frame = 2'd0;
        vb_last    = 1'b0;
        rise_last  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !rst) check("rom_addr", rom_addr, snow_addr);
            if (mon_en && (frame_sel !== last_frame || done === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: got frame=%0d done=%0b, required no change (t=%0t)",
                             frame_sel, done, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_event", {done, frame_sel}, e[2:0]);
                    if (e[3]) check("vblank_align", rise_last, 1'b1);
                end
            end
            last_frame = frame_sel;
            rise_last  = vblank && !vb_last;
            vb_last    = vblank;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b1; vblank = 1'b0; mode = 2'b00;
        cyc(3);
        check("rst_frame", frame_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_addr", rom_addr, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(2);
        check("idle_busy", busy, 0);

        // loop
        start_anim(2'b00);
        check("loop_busy", busy, 1);
        cyc(3);
        vb_adv(10, 2'd1); vb_adv(10, 2'd2); vb_adv(10, 2'd0); vb_adv(10, 2'd1);
        check("loop_busy_end", busy, 1);

        // ping-pong
        push(1'b0, 1'b0, 2'd0);
        start_anim(2'b01);
        cyc(3);
        vb_adv(10, 2'd1); vb_adv(10, 2'd2); vb_adv(10, 2'd1);
        vb_adv(10, 2'd0); vb_adv(10, 2'd1); vb_adv(10, 2'd2);

        // one-shot
        push(1'b0, 1'b0, 2'd0);
        start_anim(2'b10);
        cyc(3);
        vb_adv(10, 2'd1); vb_adv(10, 2'd2);
        push(1'b1, 1'b1, 2'd2);
        vb_pulse(10);
        check("oneshot_busy", busy, 0);
        check("oneshot_done_low", done, 0);
        repeat (5) vb_pulse(10);
        check("oneshot_hold", frame_sel, 2);
        check("oneshot_busy_hold", busy, 0);
        push(1'b0, 1'b0, 2'd0);
        start_anim(2'b10);
        check("restart_frame", frame_sel, 0);
        check("restart_busy", busy, 1);

        // several ticks per vblank
        start_anim(2'b00);
        cyc(3);
        vb_adv(20, 2'd1); vb_adv(20, 2'd2); vb_adv(20, 2'd0);

        // paused, nothing pending
        en = 1'b0;
        start_anim(2'b00);
        cyc(3);
        repeat (3) vb_pulse(10);
        check("pause_frame", frame_sel, 0);

        // paused with a pending advance
        en = 1'b1;
        cyc(6);
        en = 1'b0;
        vb_adv(10, 2'd1);
        vb_pulse(10);
        check("pause_pending_frame", frame_sel, 1);
        en = 1'b1;

        // hold
        push(1'b0, 1'b0, 2'd0);
        start_anim(2'b11);
        cyc(3);
        repeat (3) vb_pulse(10);
        check("hold_frame", frame_sel, 0);
        check("hold_busy", busy, 1);

        // tick and vblank edge in the same cycle, then consumed tick
        start_anim(2'b00);
        cyc(2);
        push(1'b1, 1'b0, 2'd1);
        vblank = 1'b1; cyc(1);
        vblank = 1'b0; cyc(1);
        vblank = 1'b1; cyc(1);
        vblank = 1'b0; cyc(7);
        check("same_cycle_frame", frame_sel, 1);

        // start on an advance cycle
        vblank = 1'b1; cyc(1);
        push(1'b0, 1'b0, 2'd0);
        start = 1'b1; mode = 2'b00; cyc(1);
        start = 1'b0; vblank = 1'b0; mode = 2'b11;
        check("start_prio_frame", frame_sel, 0);
        check("start_prio_busy", busy, 1);

        // reset mid-run
        start_anim(2'b00);
        cyc(3);
        vb_adv(10, 2'd1); vb_adv(10, 2'd2);
        check("pre_rst_frame", frame_sel, 2);
        push(1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        cyc(1);
        check("midrst_frame", frame_sel, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rom_addr", rom_addr, 0);
        rst = 1'b0;

        cyc(5);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
